comb_fp_summator: RTL and testbench
===================================

COMB_FP_SUMMATOR -- requirements
Module: comb_fp_summator

Interface
REQ-001 Parameters: none; format fixed to IEEE-754 binary32.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 a_i  input  32 (float_point_num)  addend A: sign[31], exp[30:23], mant[22:0].
REQ-005 b_i  input  32 (float_point_num)  addend B, same layout.
REQ-006 vld_i  input  1  operands valid this cycle.
REQ-007 answer_o  output  32 (float_point_num)  registered sum.
REQ-008 answer_status_o  output  5 (fp_status_t)  registered flags {valid, nan, inf, zero, inexact}, MSB to LSB in that order.

Function
REQ-009 Compute a_i + b_i per IEEE-754 binary32, round-to-nearest-ties-to-even.
REQ-010 Arithmetic path is combinational; answer_o and answer_status_o are registered, latency exactly 1 cycle from vld_i sample.
REQ-011 Cycle with vld_i=1: next edge loads the result, and status.valid=1.
REQ-012 Cycle with vld_i=0: answer_o and nan/inf/zero/inexact flags hold; status.valid=0 on next edge.
REQ-013 Back-to-back vld_i=1 accepted every cycle; no backpressure, no stall.
REQ-014 Datapath: unpack with hidden bit (0 for exp=0, exponent treated as 1); swap so |A|>=|B|; right-shift smaller mantissa by exponent difference, keeping guard, round, sticky; shift >= 27 collapses to sticky only.
REQ-015 Same signs: add mantissas; carry-out shifts right 1, exp+1, sticky preserved.
REQ-016 Different signs: subtract; normalize left by leading-zero count, limited so exp does not go below 1 (gradual underflow, denormal output).
REQ-017 Round on G/R/S with LSB; mantissa rounding overflow renormalizes and increments exp.
REQ-018 Exp reaching 255 after rounding: result +/-inf (0x7F800000 / 0xFF800000), inf=1, inexact=1.
REQ-019 Any NaN input, or +inf + -inf: result canonical qNaN 0x7FC00000, nan=1.
REQ-020 inf + finite, or inf + same-sign inf: that inf, inf=1, inexact=0.
REQ-021 Exact cancellation of non-zero operands: +0 (0x00000000); -0 + -0 = -0; +0 + -0 = +0; zero=1 for any zero result.
REQ-022 inexact=1 whenever any of G/R/S is non-zero before rounding, or on overflow.
REQ-023 Denormal inputs fully supported; no flush-to-zero.

Reset
REQ-024 While rst_i=1 at a rising edge: answer_o=0x00000000, answer_status_o=0; reset overrides vld_i.
REQ-025 Operand presented in the reset cycle is discarded; first valid result follows the first vld_i=1 cycle after rst_i deasserts.

Structure
REQ-026 Package struct_types holds float_point_num (packed sign/exp/mant), fp_status_t, and constants QNAN=0x7FC00000, EXP_MAX=8'hFF, BIAS=127.
REQ-027 One sub-module fp_lzc: 27-bit leading-zero counter, 5-bit output, purely combinational.
REQ-028 Everything else (unpack, align, add/sub, normalize, round, specials) inside comb_fp_summator, single output register stage.

Verification
REQ-029 0x3F600000 (0.875) + 0x400CCCCD (2.2), vld_i=1 -> next cycle answer_o=0x4044CCCD (3.075), status valid=1, all other flags 0.
REQ-030 0x3F800000 + 0xBF800000 -> 0x00000000, zero=1; 0x7F800000 + 0xFF800000 -> 0x7FC00000, nan=1.
REQ-031 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, inf=1, inexact=1.
REQ-032 0x3F800000 + 0x33800000 (tie) -> 0x3F800000, inexact=1; 0x3F800001 + 0x33800000 -> 0x3F800002, inexact=1.
REQ-033 0x00000001 + 0x00000001 -> 0x00000002; 0x00400000 + 0x00400000 -> 0x00800000 (denormal to normal).
REQ-034 rst_i=1 with vld_i=1 and operands applied -> answer_o=0, status=0; then vld_i=0 -> outputs hold, valid=0.

Source files
------------

// File: rtl/struct_types.sv
// Shared types and constants for the binary32 summator.
package struct_types;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] mant;
   } float_point_num;

   typedef struct packed {
      logic valid;
      logic nan;
      logic inf;
      logic zero;
      logic inexact;
   } fp_status_t;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [7:0]  EXP_MAX = 8'hFF;
   localparam logic [7:0]  BIAS    = 8'd127;

endpackage

// File: rtl/fp_lzc.sv
// 27-bit leading-zero counter; an all-zero input reports 27.
module fp_lzc (
   input  logic [26:0] data_i,
   output logic [4:0]  cnt_o
);

   // Highest set bit wins because later iterations overwrite earlier ones.
   always_comb begin
      cnt_o = 5'd27;
      for (int i = 0; i < 27; i++) begin
         cnt_o = data_i[i] ? 5'(26 - i) : cnt_o;
      end
   end

endmodule

// File: rtl/comb_fp_summator.sv
// IEEE-754 binary32 adder, round-to-nearest-even: combinational datapath, one output register stage.
module comb_fp_summator
   import struct_types::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        vld_i,
   output logic [31:0] answer_o,
   output logic [4:0]  answer_status_o
);

   float_point_num fa_s, fb_s, big_s, sml_s;
   logic [7:0]  big_exp_s, sml_exp_s, exp_diff_s, lshift_s;
   logic [26:0] big_man_s, sml_man_s, aligned_s, diff_s, norm_s;
   logic [53:0] shifted_s;
   logic [27:0] sum_s;
   logic [24:0] rounded_s;
   logic [23:0] fin_man_s;
   logic [8:0]  norm_exp_s, fin_exp_s;
   logic [7:0]  exp_field_s;
   logic [4:0]  lzc_s;
   logic        eff_sub_s, res_sign_s, round_up_s;
   logic        nan_a_s, nan_b_s, inf_a_s, inf_b_s;
   logic [31:0] res_s, ans_d, ans_q;
   fp_status_t  flags_s, st_d, st_q;

   fp_lzc u_lzc (
      .data_i (diff_s),
      .cnt_o  (lzc_s)
   );

   // Unpack, align, add/subtract, normalize and round.
   always_comb begin
      fa_s  = a_i;
      fb_s  = b_i;
      big_s = (fa_s[30:0] >= fb_s[30:0]) ? fa_s : fb_s;
      sml_s = (fa_s[30:0] >= fb_s[30:0]) ? fb_s : fa_s;
      // Denormals use exponent 1 with a clear hidden bit.
      big_exp_s  = (big_s.exp == 8'h00) ? 8'h01 : big_s.exp;
      sml_exp_s  = (sml_s.exp == 8'h00) ? 8'h01 : sml_s.exp;
      big_man_s  = {big_s.exp != 8'h00, big_s.mant, 3'b000};
      sml_man_s  = {sml_s.exp != 8'h00, sml_s.mant, 3'b000};
      exp_diff_s = big_exp_s - sml_exp_s;
      shifted_s  = {sml_man_s, 27'h0} >> exp_diff_s;
      if (exp_diff_s >= 8'd27) begin
         aligned_s = {26'h0, |sml_man_s};
      end else begin
         aligned_s = {shifted_s[53:28], shifted_s[27] | (|shifted_s[26:0])};
      end

      eff_sub_s  = big_s.sign ^ sml_s.sign;
      sum_s      = {1'b0, big_man_s} + {1'b0, aligned_s};
      diff_s     = big_man_s - aligned_s;
      res_sign_s = big_s.sign;
      lshift_s   = 8'h00;
      if (!eff_sub_s) begin
         if (sum_s[27]) begin
            norm_s     = {sum_s[27:2], sum_s[1] | sum_s[0]};
            norm_exp_s = {1'b0, big_exp_s} + 9'd1;
         end else begin
            norm_s     = sum_s[26:0];
            norm_exp_s = {1'b0, big_exp_s};
         end
      end else begin
         // Left shift is capped so the exponent stops at 1 (gradual underflow).
         lshift_s   = ({3'b000, lzc_s} < (big_exp_s - 8'd1)) ? {3'b000, lzc_s} : (big_exp_s - 8'd1);
         norm_s     = diff_s << lshift_s;
         norm_exp_s = {1'b0, big_exp_s} - {1'b0, lshift_s};
         res_sign_s = (diff_s == 27'h0) ? 1'b0 : big_s.sign;
      end

      round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
      rounded_s  = {1'b0, norm_s[26:3]} + {24'h0, round_up_s};
      if (rounded_s[24]) begin
         fin_man_s = rounded_s[24:1];
         fin_exp_s = norm_exp_s + 9'd1;
      end else begin
         fin_man_s = rounded_s[23:0];
         fin_exp_s = norm_exp_s;
      end
      exp_field_s = fin_man_s[23] ? fin_exp_s[7:0] : 8'h00;
   end

   // Special-operand and overflow handling over the finite result.
   always_comb begin
      nan_a_s = (fa_s.exp == EXP_MAX) && (fa_s.mant != 23'h0);
      nan_b_s = (fb_s.exp == EXP_MAX) && (fb_s.mant != 23'h0);
      inf_a_s = (fa_s.exp == EXP_MAX) && (fa_s.mant == 23'h0);
      inf_b_s = (fb_s.exp == EXP_MAX) && (fb_s.mant == 23'h0);
      flags_s = 5'b0_0000;
      flags_s.valid = 1'b1;
      if (nan_a_s || nan_b_s || (inf_a_s && inf_b_s && (fa_s.sign != fb_s.sign))) begin
         res_s       = QNAN;
         flags_s.nan = 1'b1;
      end else if (inf_a_s || inf_b_s) begin
         res_s       = inf_a_s ? a_i : b_i;
         flags_s.inf = 1'b1;
      end else if (fin_exp_s >= 9'd255) begin
         res_s           = {res_sign_s, EXP_MAX, 23'h0};
         flags_s.inf     = 1'b1;
         flags_s.inexact = 1'b1;
      end else begin
         res_s           = {res_sign_s, exp_field_s, fin_man_s[22:0]};
         flags_s.zero    = (fin_man_s == 24'h0);
         flags_s.inexact = |norm_s[2:0];
      end
   end

   // Load a new result on valid; otherwise hold value and flags, drop valid.
   always_comb begin
      if (vld_i) begin
         ans_d = res_s;
         st_d  = flags_s;
      end else begin
         ans_d       = ans_q;
         st_d        = st_q;
         st_d.valid  = 1'b0;
      end
   end

   // Output register stage with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ans_q <= 32'h0;
         st_q  <= 5'b0_0000;
      end else begin
         ans_q <= ans_d;
         st_q  <= st_d;
      end
   end

   assign answer_o        = ans_q;
   assign answer_status_o = st_q;

endmodule

// File: tb/tb_comb_fp_summator.sv
// Directed scoreboard bench for comb_fp_summator: expected results queued at drive time, popped after each edge.
module tb_comb_fp_summator;
   import struct_types::*;

   logic        clk_i = 1'b0;
   logic        rst_i, vld_i;
   logic [31:0] a_i, b_i, answer_o;
   logic [4:0]  answer_status_o;

   typedef struct packed {
      logic [31:0] ans;
      logic [4:0]  st;
   } exp_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [3:0]  f;   // nan, inf, zero, inexact
   } vec_t;

   exp_t        sb_q[$];
   vec_t        vecs[20];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] last_ans = 32'h0;
   logic [3:0]  last_fl  = 4'h0;

   comb_fp_summator dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .a_i             (a_i),
      .b_i             (b_i),
      .vld_i           (vld_i),
      .answer_o        (answer_o),
      .answer_status_o (answer_status_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   task automatic step(input logic rst, input logic vld, input vec_t v, input string tag);
      exp_t e, o;
      @(negedge clk_i);
      rst_i = rst;
      vld_i = vld;
      a_i   = v.a;
      b_i   = v.b;
      if (rst) begin
         e.ans = 32'h0; e.st = 5'h00;
         last_ans = 32'h0; last_fl = 4'h0;
      end else if (vld) begin
         e.ans = v.r; e.st = {1'b1, v.f};
         last_ans = v.r; last_fl = v.f;
      end else begin
         e.ans = last_ans; e.st = {1'b0, last_fl};
      end
      sb_q.push_back(e);
      @(posedge clk_i);
      #1;
      o = sb_q.pop_front();
      check_val({tag, ".ans"}, answer_o, o.ans);
      check_val({tag, ".st"}, {27'h0, answer_status_o}, {27'h0, o.st});
   endtask

   initial begin
      vec_t nil;
      nil = {32'h3F80_0000, 32'h3F80_0000, 32'h0, 4'h0};
      vecs[0]  = {32'h3F60_0000, 32'h400C_CCCD, 32'h4044_CCCD, 4'b0000};
      vecs[1]  = {32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 4'b0010};
      vecs[2]  = {32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b1000};
      vecs[3]  = {32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 4'b0101};
      vecs[4]  = {32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 4'b0001};
      vecs[5]  = {32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, 4'b0001};
      vecs[6]  = {32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 4'b0000};
      vecs[7]  = {32'h0040_0000, 32'h0040_0000, 32'h0080_0000, 4'b0000};
      vecs[8]  = {32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 4'b0010};
      vecs[9]  = {32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0010};
      vecs[10] = {32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 4'b0100};
      vecs[11] = {32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000, 4'b0100};
      vecs[12] = {32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000};
      vecs[13] = {32'h4000_0000, 32'hBF80_0000, 32'h3F80_0000, 4'b0000};
      vecs[14] = {32'h0080_0000, 32'h8000_0001, 32'h007F_FFFF, 4'b0000};
      vecs[15] = {32'h3F80_0000, 32'h0000_0001, 32'h3F80_0000, 4'b0001};
      vecs[16] = {32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0101};
      vecs[17] = {32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4'b0000};
      vecs[18] = {32'hC040_0000, 32'h3F80_0000, 32'hC000_0000, 4'b0000};
      vecs[19] = {32'h3FFF_FFFF, 32'h3380_0000, 32'h4000_0000, 4'b0001};

      rst_i = 1'b1; vld_i = 1'b0; a_i = 32'h0; b_i = 32'h0;
      step(1'b1, 1'b1, nil, "reset_vld");
      step(1'b1, 1'b0, nil, "reset_idle");
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, vecs[i], $sformatf("vec%0d", i));
      end
      step(1'b0, 1'b0, vecs[0], "hold0");
      step(1'b0, 1'b0, vecs[1], "hold1");
      step(1'b0, 1'b1, vecs[0], "revalid");
      step(1'b0, 1'b1, vecs[3], "b2b");
      step(1'b1, 1'b1, vecs[5], "mid_reset");
      step(1'b0, 1'b0, vecs[5], "post_reset_hold");
      step(1'b0, 1'b1, vecs[7], "post_reset_vld");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
